myproject_mul_share_arbiter: RTL and testbench
==============================================

// Module: myproject_mul_share_arbiter
// PURPOSE
//  Shares one 21s x 6u -> 27 full-precision multiplier between NUM_REQ requesters.
//  Used by the conv/dense layers to share a multiplier instead of replicating one per lane.
//  Round-robin arbitration, valid/ready on both sides, two-stage pipeline (operand reg, result reg).
//  Each result is tagged with the requester index so the caller can demultiplex it.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DIN0_W    21  signed operand width (weight/activation)
//  DIN1_W    6   unsigned operand width
//  DOUT_W    27  product width = DIN0_W+DIN1_W, no truncation
//  ID_W      2   requester tag width = clog2(NUM_REQ)
// PORTS
//  ap_clk     in   1               clock, rising edge
//  ap_rst     in   1               asynchronous, active-high reset
//  req_valid  in   NUM_REQ         per-requester operand valid
//  req_ready  out  NUM_REQ         per-requester grant/accept (one-hot or zero)
//  req_din0   in   NUM_REQ*DIN0_W  packed signed operands, lane i at [i*DIN0_W +: DIN0_W]
//  req_din1   in   NUM_REQ*DIN1_W  packed unsigned operands, lane i at [i*DIN1_W +: DIN1_W]
//  res_valid  out  1               product valid
//  res_ready  in   1               downstream accepts product
//  res_dout   out  DOUT_W          signed product
//  res_id     out  ID_W            index of the requester that owns res_dout
//  busy       out  1               s1_valid | s2_valid
// BEHAVIOUR
//  - Reset (async assert, sync deassert in the caller's domain): s1_valid=0, s2_valid=0, rr_ptr=0.
//    res_valid=0, res_dout=0, res_id=0, busy=0, req_ready=0. In-flight ops are dropped.
//  - Transfer on req_valid[i]&req_ready[i] or res_valid&res_ready. The requester holds valid/data until accepted.
//  - advance2 = !s2_valid | res_ready; advance1 = !s1_valid | advance2.
//  - Grant (combinational): when advance1=1, pick the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    req_ready = one-hot of the winner. No grant when advance1=0 or no request.
//    req_ready may depend on req_valid; req_valid must not depend on req_ready.
//  - On grant i: s1 <= {din0_i, din1_i, id=i}, s1_valid<=1, rr_ptr <= (i+1) mod NUM_REQ.
//    With no grant and advance1=1: s1_valid<=0. rr_ptr changes only on a grant.
//  - When advance2=1: s2 <= {s1 product, s1 id}, s2_valid<=s1_valid. Otherwise s2 is held stable.
//    res_* = s2 registers.
//  - Latency: accept at cycle T -> res_valid at T+2 (res_ready=1). Throughput: 1 result/cycle.
//  - Arithmetic: dout = $signed(din0) * $signed({1'b0,din1}), full DOUT_W.
//    Range -2^20*63 .. (2^20-1)*63; no saturation, no rounding.
//  - Stall: res_ready=0 with s2_valid=1 -> s2 is held. s1 holds if valid. Grant only if s1 is empty.
//    No loss and no duplication.
//  - Results leave in acceptance order. Ordering per requester is preserved.
//  - Fairness: a requester with continuous valid is granted within NUM_REQ grants.
//  - Single requester active: granted every cycle that advance1=1.
// STRUCTURE
//  - Package myproject_mul_arb_pkg: NUM_REQ, DIN0_W, DIN1_W, DOUT_W, ID_W constants and the s1/s2 stage struct typedefs.
//  - Sub-module myproject_rr_arbiter (req vector, enable, ptr -> one-hot grant, grant index).
//  - Instantiates the existing myproject_mul_21s_6ns_27_1_1 cell between s1 and s2.
// TESTING
//  1 Reset: assert ap_rst mid-stream with s1 and s2 full -> res_valid, busy, req_ready all 0 immediately.
//    First grant after reset goes to req 0 when all requesters are valid.
//  2 Arithmetic: req1 din0=-1048576 (0x100000), din1=63 -> res_dout=-66060288, res_id=1, 2 cycles after accept.
//    din0=1048575, din1=63 -> 66060225. din1=0 -> 0.
//  3 Round-robin: all 4 valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1...
//    res_id sequence matches, one result/cycle.
//  4 Backpressure: res_ready=0 for 5 cycles with a stream in flight -> res_dout/res_id held stable.
//    At most 2 ops pending, req_ready=0 once s1 is full. Exact sequence resumes with no loss or duplication.
//  5 Sparse/skip: only req2 and req3 valid, rr_ptr=0 -> grants 2,3,2,3.
//    req0 raised later is granted within 4 grants.
//  6 Random: constrained-random valids, operands, res_ready for 10k cycles.
//    A scoreboard per requester checks product = reference model and in-order delivery.

Source files
------------

// File: rtl/myproject_mul_share_arbiter_pkg.sv
// Shared constants and pipeline-stage records for the multiplier-sharing arbiter.
// The round-robin pointer helper is kept here so the arbiter and the top agree on wrap rules.
package myproject_mul_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int DIN0_W  = 21;
    localparam int DIN1_W  = 6;
    localparam int DOUT_W  = DIN0_W + DIN1_W;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef struct packed {
        logic signed [DIN0_W-1:0] din0;
        logic        [DIN1_W-1:0] din1;
        logic        [ID_W-1:0]   id;
    } s1_t;

    typedef struct packed {
        logic signed [DOUT_W-1:0] dout;
        logic        [ID_W-1:0]   id;
    } s2_t;

    // Pointer moves to the slot after the winner; NUM_REQ need not be a power of two.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/myproject_mul_share_arbiter_if.sv
// Requester-side and result-side handshake bundle for the shared multiplier.
// master = requesters/consumer, slave = arbiter.
interface myproject_mul_share_arbiter_if;
    import myproject_mul_arb_pkg::*;

    logic        [NUM_REQ-1:0]        req_valid;
    logic        [NUM_REQ-1:0]        req_ready;
    logic        [NUM_REQ*DIN0_W-1:0] req_din0;
    logic        [NUM_REQ*DIN1_W-1:0] req_din1;
    logic                             res_valid;
    logic                             res_ready;
    logic signed [DOUT_W-1:0]         res_dout;
    logic        [ID_W-1:0]           res_id;

    modport master (
        output req_valid, req_din0, req_din1, res_ready,
        input  req_ready, res_valid, res_dout, res_id
    );

    modport slave (
        input  req_valid, req_din0, req_din1, res_ready,
        output req_ready, res_valid, res_dout, res_id
    );

endinterface

// File: rtl/myproject_mul_21s_6ns_27_1_1.sv
// Combinational 21-bit signed x 6-bit unsigned multiplier, full 27-bit product.
module myproject_mul_21s_6ns_27_1_1 #(
    parameter int din0_WIDTH = 21,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 27
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    logic signed [dout_WIDTH-1:0] a_ext;
    logic signed [dout_WIDTH-1:0] b_ext;

    // din1 is unsigned: a zero MSB keeps it non-negative before signed extension.
    assign a_ext = dout_WIDTH'($signed(din0));
    assign b_ext = dout_WIDTH'($signed({1'b0, din1}));
    assign dout  = a_ext * b_ext;

endmodule

// File: rtl/myproject_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module myproject_rr_arbiter
    import myproject_mul_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_vld
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (int'(ptr) + k) % NUM_REQ;
                if (!gnt_vld && req[j]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = ID_W'(j);
                    gnt[j]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/myproject_mul_share_arbiter.sv
// One shared 21s x 6u multiplier serving NUM_REQ requesters through a round-robin grant,
// with an operand stage (p1) and a result stage (p2); results carry the owner's index.
module myproject_mul_share_arbiter
    import myproject_mul_arb_pkg::*;
(
    input  logic                            ap_clk,
    input  logic                            ap_rst,
    myproject_mul_share_arbiter_if.slave    bus,
    output logic                            busy
);

    logic               vld_p1;
    logic               vld_p2;
    s1_t                s1_p1;
    s2_t                s2_p2;
    s1_t                s1_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_vld;
    logic               advance1;
    logic               advance2;
    logic [DOUT_W-1:0]  prod;

    assign advance2 = !vld_p2 || bus.res_ready;
    assign advance1 = !vld_p1 || advance2;

    // Grants are suppressed while reset is held so req_ready reads zero during reset.
    myproject_rr_arbiter u_arb (
        .req     (bus.req_valid),
        .en      (advance1 && !ap_rst),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        s1_nxt      = '0;
        s1_nxt.din0 = bus.req_din0[int'(gnt_idx)*DIN0_W +: DIN0_W];
        s1_nxt.din1 = bus.req_din1[int'(gnt_idx)*DIN1_W +: DIN1_W];
        s1_nxt.id   = gnt_idx;
    end

    myproject_mul_21s_6ns_27_1_1 #(
        .din0_WIDTH (DIN0_W),
        .din1_WIDTH (DIN1_W),
        .dout_WIDTH (DOUT_W)
    ) u_mul (
        .din0 (s1_p1.din0),
        .din1 (s1_p1.din1),
        .dout (prod)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            s1_p1  <= '0;
            s2_p2  <= '0;
            rr_ptr <= '0;
        end else begin
            // p1: operand capture from the granted lane
            if (advance1) begin
                vld_p1 <= gnt_vld;
                if (gnt_vld) begin
                    s1_p1  <= s1_nxt;
                    rr_ptr <= next_ptr(gnt_idx);
                end
            end
            // p2: product and owner tag, held while the consumer stalls
            if (advance2) begin
                vld_p2      <= vld_p1;
                s2_p2.dout  <= prod;
                s2_p2.id    <= s1_p1.id;
            end
        end
    end

    assign bus.req_ready = gnt;
    assign bus.res_valid = vld_p2;
    assign bus.res_dout  = s2_p2.dout;
    assign bus.res_id    = s2_p2.id;
    assign busy          = vld_p1 || vld_p2;

endmodule

// File: tb/tb_myproject_mul_share_arbiter.sv
// Directed and random stimulus for the shared multiplier arbiter with a global result scoreboard.
module tb_myproject_mul_share_arbiter;
    import myproject_mul_arb_pkg::*;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic busy;

    myproject_mul_share_arbiter_if bus();

    myproject_mul_share_arbiter dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.slave),
        .busy   (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int     id;
        longint dout;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int n_res = 0;
    int mode  = 0;

    logic signed [DIN0_W-1:0] din0 [NUM_REQ];
    logic        [DIN1_W-1:0] din1 [NUM_REQ];
    logic        [NUM_REQ-1:0] vld = '0;
    logic                      rr  = 1'b1;

    logic [NUM_REQ-1:0] last_gnt;
    logic               last_res_valid;
    longint             last_dout;
    int                 last_id;

    function automatic longint ref_mul(longint a, longint b);
        return a * b;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = vld;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_din0[i*DIN0_W +: DIN0_W] = din0[i];
            bus.req_din1[i*DIN1_W +: DIN1_W] = din1[i];
        end
        bus.res_ready = rr;
    endtask

    task automatic rand_lane(input int i);
        case ($urandom_range(0, 7))
            0:       din0[i] = -(DIN0_W'(1) <<< (DIN0_W - 1));
            1:       din0[i] = (DIN0_W'(1) <<< (DIN0_W - 1)) - 1;
            default: din0[i] = DIN0_W'($urandom);
        endcase
        din1[i] = ($urandom_range(0, 7) == 0) ? DIN1_W'(63) : DIN1_W'($urandom);
    endtask

    task automatic observe();
        exp_t e;
        last_gnt       = bus.req_ready;
        last_res_valid = bus.res_valid;
        last_dout      = bus.res_dout;
        last_id        = int'(bus.res_id);
        check("gnt_onehot0", 64'($onehot0(bus.req_ready)), 64'(1));
        if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("sb_dout", last_dout, e.dout);
                check("sb_id", last_id, e.id);
                n_res++;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                e.id   = i;
                e.dout = ref_mul(longint'(din0[i]), longint'(din1[i]));
                sb.push_back(e);
            end
        end
    endtask

    task automatic update();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_gnt[i] && vld[i]) begin
                if (mode == 0) vld[i] = 1'b0;
                else rand_lane(i);
            end
            if (mode == 2 && (!vld[i] || last_gnt[i])) begin
                vld[i] = ($urandom_range(0, 2) != 0);
                rand_lane(i);
            end
        end
        if (mode == 2) rr = ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick();
        @(negedge ap_clk);
        observe();
        @(posedge ap_clk);
        #1;
        update();
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 12) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        check("drain_idle", 64'(busy), 64'(0));
    endtask

    task automatic arith(input logic signed [DIN0_W-1:0] a, input logic [DIN1_W-1:0] b, input longint exp);
        din0[1] = a;
        din1[1] = b;
        vld     = 4'b0010;
        drive();
        tick();
        check("arith_accept", last_gnt, 4'b0010);
        tick();
        check("arith_not_yet", last_res_valid, 0);
        tick();
        check("arith_valid", last_res_valid, 1);
        check("arith_dout", last_dout, exp);
        check("arith_id", last_id, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        longint hold_d;
        int     hold_id;
        bit     found;
        for (int i = 0; i < NUM_REQ; i++) rand_lane(i);
        vld = '0;
        rr  = 1'b1;
        drive();
        repeat (2) @(posedge ap_clk);
        #1;

        // Reset held with every lane requesting.
        vld = '1;
        drive();
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_res_dout", bus.res_dout, 0);
        check("rst_res_id", bus.res_id, 0);

        // Round-robin with all four lanes valid, first grant to lane 0.
        ap_rst = 1'b0;
        mode   = 1;
        drive();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_gnt", last_gnt, 64'(1) << (k % 4));
            if (k >= 2) begin
                check("rr_res_valid", last_res_valid, 1);
                check("rr_res_id", last_id, (k - 2) % 4);
            end
        end

        // Backpressure for five cycles with both stages full.
        rr = 1'b0;
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                hold_d  = last_dout;
                hold_id = last_id;
            end
            check("bp_hold_valid", last_res_valid, 1);
            check("bp_hold_dout", last_dout, hold_d);
            check("bp_hold_id", last_id, hold_id);
            check("bp_no_grant", last_gnt, 0);
            check("bp_busy", busy, 1);
        end
        rr = 1'b1;
        drive();
        repeat (6) tick();

        // Asynchronous reset mid-stream with both stages full.
        rr = 1'b0;
        drive();
        tick();
        tick();
        ap_rst = 1'b1;
        #2;
        check("midrst_res_valid", bus.res_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req_ready", bus.req_ready, 0);
        sb.delete();
        last_gnt = '0;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        rr     = 1'b1;
        vld    = '1;
        drive();
        tick();
        check("midrst_first_gnt", last_gnt, 4'b0001);
        mode = 0;
        vld  = '0;
        drive();
        drain();

        // Arithmetic corners on lane 1.
        arith(-21'sd1048576, 6'd63, -64'sd66060288);
        arith(21'sd1048575, 6'd63, 64'sd66060225);
        arith(-21'sd12345, 6'd0, 64'sd0);
        drain();

        // Sparse requests after reset: lanes 2 and 3, then lane 0 joins.
        ap_rst = 1'b1;
        #2;
        sb.delete();
        last_gnt = '0;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        mode   = 1;
        vld    = 4'b1100;
        drive();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sparse_gnt", last_gnt, (k % 2 == 0) ? 4'b0100 : 4'b1000);
        end
        vld[0] = 1'b1;
        drive();
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            tick();
            if (last_gnt[0]) found = 1'b1;
        end
        check("fair_req0", found, 1);
        mode = 0;
        vld  = '0;
        drive();
        drain();

        // Constrained-random traffic and backpressure.
        n_res = 0;
        mode  = 2;
        for (int k = 0; k < 10000; k++) tick();
        mode = 0;
        vld  = '0;
        rr   = 1'b1;
        drive();
        drain();
        check("rand_activity", 64'(n_res > 1000), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
